// File: rtl/spn_sbox_pkg.sv
// Shared definitions for the SPN cipher cores: 4-bit S-box tables, nibble
// substitution helpers and the decrypt FSM state type.
package spn_sbox_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
        4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'hE, 4'h3, 4'h4, 4'h8, 4'h1, 4'hC, 4'hA, 4'hF,
        4'h7, 4'hD, 4'h9, 4'h6, 4'hB, 4'h2, 4'h0, 4'h5
    };

    function automatic logic [3:0] sbox_substitute(input logic [3:0] nib);
        return SBOX[nib];
    endfunction

    function automatic logic [3:0] sbox_inv_substitute(input logic [3:0] nib);
        return SBOX_INV[nib];
    endfunction

endpackage

// File: rtl/spn_inv_round.sv
// One combinational inverse SPN round: undo the 8-bit left rotation,
// undo the nibble substitution, then mix in the round key.
module spn_inv_round
    import spn_sbox_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] data_in,
    input  logic [DW-1:0] round_key,
    output logic [DW-1:0] data_out
);

    logic [DW-1:0] rotated;
    logic [DW-1:0] substituted;

    always_comb begin
        rotated     = {data_in[7:0], data_in[DW-1:8]};
        substituted = '0;
        for (int n = 0; n < DW / 4; n++) begin
            substituted[4*n +: 4] = sbox_inv_substitute(rotated[4*n +: 4]);
        end
        data_out = substituted ^ round_key;
    end

endmodule

// File: rtl/spn_decrypt_core.sv
// Iterative SPN decryption core: one inverse round per clock, valid/ready
// handshake on both sides, result held until the consumer takes it.
module spn_decrypt_core
    import spn_sbox_pkg::*;
#(
    parameter int DW = 16,
    parameter int NR = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic [DW*(NR+1)-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data
);

    localparam int CW = $clog2(NR) + 1;

    state_t                 fsm_q;
    logic [DW-1:0]          data_q;
    logic [DW*(NR+1)-1:0]   key_q;
    logic [CW-1:0]          cnt_q;
    logic [DW-1:0]          round_key;
    logic [DW-1:0]          round_out;

    // Rounds run from NR-1 down to 0, so the counter doubles as the key index.
    assign round_key = key_q[int'(cnt_q) * DW +: DW];
    assign out_data  = data_q;

    spn_inv_round #(.DW(DW)) u_inv_round (
        .data_in   (data_q),
        .round_key (round_key),
        .data_out  (round_out)
    );

    // The final whitening key is stripped at accept time so RUN only does rounds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= IDLE;
            data_q    <= '0;
            key_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data ^ in_key[DW*NR +: DW];
                        key_q    <= in_key;
                        cnt_q    <= CW'(NR - 1);
                        in_ready <= 1'b0;
                        fsm_q    <= RUN;
                    end
                end
                RUN: begin
                    data_q <= round_out;
                    if (cnt_q == '0) begin
                        out_valid <= 1'b1;
                        fsm_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    fsm_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spn_decrypt_core.sv
// Self-checking bench for spn_decrypt_core: directed vectors, randomized
// encrypt-then-decrypt round trips with stalls, hold, reset-abort and throughput.
module tb_spn_decrypt_core;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int KW = DW * (NR + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [KW-1:0] in_key;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    int n_compared   = 0;
    int n_mismatched = 0;

    localparam logic [3:0] FWD [16] = '{
        4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
        4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7
    };

    always #5 clk = ~clk;

    spn_decrypt_core #(.DW(DW), .NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Golden forward cipher; the DUT is checked by decrypting its output.
    function automatic logic [DW-1:0] encrypt(input logic [DW-1:0] pt, input logic [KW-1:0] key);
        logic [DW-1:0] x;
        logic [DW-1:0] s;
        x = pt;
        for (int r = 0; r < NR; r++) begin
            x = x ^ key[DW*r +: DW];
            s = '0;
            for (int n = 0; n < DW / 4; n++) s[4*n +: 4] = FWD[x[4*n +: 4]];
            x = (s << 8) | (s >> 8);
        end
        return x ^ key[DW*NR +: DW];
    endfunction

    function automatic logic [KW-1:0] rand_key();
        logic [KW-1:0] k;
        for (int r = 0; r <= NR; r++) k[DW*r +: DW] = DW'($urandom);
        return k;
    endfunction

    task automatic do_transaction(input logic [DW-1:0] ct, input logic [KW-1:0] key,
                                  output logic [DW-1:0] data, output int lat, output bit ok);
        int w;
        ok   = 1'b1;
        lat  = 0;
        data = 'x;
        w    = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            return;
        end
        in_valid = 1'b1;
        in_data  = ct;
        in_key   = key;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            ok = 1'b0;
            return;
        end
        data      = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_compared++;
        if (out_data !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_out_data: got %h want 0000", out_data);
        end
    endtask

    task automatic test_directed();
        logic [DW-1:0] data;
        logic [KW-1:0] key;
        int            lat;
        bit            ok;

        do_transaction(16'h0000, '0, data, lat, ok);
        n_compared++;
        if (!ok || data !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL zero_vector: got %h ok=%0d want 0000", data, ok);
        end
        n_compared++;
        if (lat !== NR) begin
            n_mismatched++;
            $display("[TB] FAIL zero_latency: got %0d want %0d", lat, NR);
        end

        do_transaction(16'hEEEE, '0, data, lat, ok);
        n_compared++;
        if (!ok || data !== 16'hEEEE) begin
            n_mismatched++;
            $display("[TB] FAIL eeee_vector: got %h ok=%0d want eeee", data, ok);
        end

        key = '0;
        key[DW*NR +: DW] = 16'h1234;
        do_transaction(16'h1234, key, data, lat, ok);
        n_compared++;
        if (!ok || data !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL final_key_vector: got %h ok=%0d want 0000", data, ok);
        end
    endtask

    task automatic test_random(input int n);
        logic [DW-1:0] exp_q [$];
        int            received;
        received = 0;
        fork
            begin : producer
                for (int i = 0; i < n; i++) begin
                    logic [DW-1:0] pt;
                    logic [KW-1:0] k;
                    int            gap;
                    int            w;
                    bit            acc;
                    pt  = DW'($urandom);
                    k   = rand_key();
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        in_valid = 1'b0;
                        in_data  = DW'($urandom);
                        in_key   = rand_key();
                        @(posedge clk); #1;
                    end
                    in_valid = 1'b1;
                    in_data  = encrypt(pt, k);
                    in_key   = k;
                    w        = 0;
                    acc      = 1'b0;
                    while (!acc && w < 200) begin
                        acc = in_ready;
                        if (acc) exp_q.push_back(pt);
                        @(posedge clk); #1;
                        w++;
                    end
                    if (!acc) break;
                end
                in_valid = 1'b0;
            end
            begin : consumer
                int cycles;
                logic [DW-1:0] expv;
                cycles = 0;
                while (received < n && cycles < n * 40) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        n_compared++;
                        if (exp_q.size() == 0) begin
                            n_mismatched++;
                            $display("[TB] FAIL random_unexpected: got %h want none", out_data);
                        end else begin
                            expv = exp_q.pop_front();
                            if (out_data !== expv) begin
                                n_mismatched++;
                                $display("[TB] FAIL random_data #%0d: got %h want %h", received, out_data, expv);
                            end
                        end
                        received++;
                    end
                    @(posedge clk); #1;
                    cycles++;
                end
                out_ready = 1'b0;
            end
        join
        n_compared++;
        if (received !== n || exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL random_count: got %0d outputs (%0d pending) want %0d", received, exp_q.size(), n);
        end
    endtask

    task automatic test_hold();
        logic [DW-1:0] pt;
        logic [KW-1:0] k;
        pt = DW'($urandom);
        k  = rand_key();
        in_valid = 1'b1;
        in_data  = encrypt(pt, k);
        in_key   = k;
        @(posedge clk); #1;
        for (int c = 1; c <= NR + 10; c++) begin
            in_data = DW'($urandom);
            in_key  = rand_key();
            @(posedge clk); #1;
            n_compared++;
            if (in_ready !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL hold_in_ready c=%0d: got %b want 0", c, in_ready);
            end
            n_compared++;
            if (c < NR && out_valid !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL hold_early_valid c=%0d: got %b want 0", c, out_valid);
            end else if (c >= NR && (out_valid !== 1'b1 || out_data !== pt)) begin
                n_mismatched++;
                $display("[TB] FAIL hold_result c=%0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, pt);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL hold_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        logic [DW-1:0] pt;
        logic [KW-1:0] k;
        logic [DW-1:0] data;
        int            lat;
        bit            ok;
        bit            rose;
        pt = DW'($urandom);
        k  = rand_key();
        in_valid = 1'b1;
        in_data  = encrypt(pt, k);
        in_key   = k;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        n_compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL abort_reset_state: got r=%b v=%b d=%h want r=1 v=0 d=0000", in_ready, out_valid, out_data);
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        rose = 1'b0;
        repeat (NR + 4) begin
            @(posedge clk); #1;
            rose |= out_valid;
        end
        n_compared++;
        if (rose !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_no_output: got out_valid=1 want 0");
        end
        pt = DW'($urandom);
        k  = rand_key();
        do_transaction(encrypt(pt, k), k, data, lat, ok);
        n_compared++;
        if (!ok || data !== pt || lat !== NR) begin
            n_mismatched++;
            $display("[TB] FAIL abort_recovery: got %h lat=%0d ok=%0d want %h lat=%0d", data, lat, ok, pt, NR);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] pt;
        logic [KW-1:0] k;
        int            rise_at [2];
        int            nrise;
        int            cyc;
        bit            prev;
        pt        = DW'($urandom);
        k         = rand_key();
        in_valid  = 1'b1;
        in_data   = encrypt(pt, k);
        in_key    = k;
        out_ready = 1'b1;
        nrise     = 0;
        cyc       = 0;
        prev      = 1'b0;
        while (nrise < 2 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid && !prev) begin
                rise_at[nrise] = cyc;
                nrise++;
                n_compared++;
                if (out_data !== pt) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_data: got %h want %h", out_data, pt);
                end
            end
            prev = out_valid;
        end
        in_valid = 1'b0;
        n_compared++;
        if (nrise != 2 || rise_at[1] - rise_at[0] != NR + 2) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_spacing: got %0d rises spacing %0d want 2 rises spacing %0d",
                     nrise, (nrise == 2) ? rise_at[1] - rise_at[0] : -1, NR + 2);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(1000);
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spn_decrypt_core.md
SPN_DECRYPT_CORE -- requirements
Module: spn_decrypt_core

Interface
REQ-001 SHALL have parameter DW, 16, block width in bits (4 nibbles).
REQ-002 SHALL have parameter NR, 4, number of rounds (1..8).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  ciphertext request valid.
REQ-006 SHALL have port in_ready  output  1  core can accept a request.
REQ-007 SHALL have port in_data  input  DW  ciphertext block.
REQ-008 SHALL have port in_key  input  DW*(NR+1)  round keys; K_r = in_key[DW*r +: DW], r=0..NR.
REQ-009 SHALL have port out_valid  output  1  plaintext valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts plaintext.
REQ-011 SHALL have port out_data  output  DW  plaintext block.

Function
REQ-012 SHALL invert the team encryption: enc = for r=0..NR-1 {x = P(S(x ^ K_r))}; ct = x ^ K_NR; P = rotate left 8 bits; S = 4 parallel 4-bit S-boxes.
REQ-013 SHALL compute inverse round as x = S^-1(P^-1(x)) ^ K_r, P^-1 = rotate right 8 bits.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL accept on in_valid&&in_ready: load state reg with in_data ^ K_NR, latch in_key into key reg, set round counter to NR-1, go RUN.
REQ-017 SHALL, each RUN cycle, apply one inverse round with latched K_counter; if counter==0 go DONE, else decrement.
REQ-018 SHALL assert out_valid exactly NR cycles after the accepting edge; out_data = state reg, stable while out_valid.
REQ-019 SHALL, in DONE, return to IDLE on out_ready; hold out_valid/out_data indefinitely otherwise.
REQ-020 SHALL ignore in_valid, in_data, in_key outside the accepting edge (changes during RUN/DONE have no effect).
REQ-021 SHALL ignore out_ready outside DONE.
REQ-022 SHALL not accept a new request in the DONE->IDLE cycle; minimum throughput NR+2 cycles per block.
REQ-023 SHALL use a counter of width $clog2(NR)+1 bits with no wrap-around.

Reset
REQ-024 SHALL on rst: FSM=IDLE, state reg=0, key reg=0, counter=0, out_valid=0, in_ready=1 after release, out_data=0.
REQ-025 SHALL abort any RUN/DONE transaction on rst with no output produced; first post-reset accept behaves normally.

Structure
REQ-026 SHALL place forward table SBOX = {E,4,D,1,2,F,B,8,3,A,6,C,5,9,0,7}, inverse table SBOX_INV = {E,3,4,8,1,C,A,F,7,D,9,6,B,2,0,5}, sbox_substitute and sbox_inv_substitute functions, and the FSM state typedef in the shared package spn_sbox_pkg.
REQ-027 SHALL instantiate one combinational sub-module spn_inv_round (data_in, round_key, data_out) implementing REQ-013; FSM, counter and registers in spn_decrypt_core.

Verification
REQ-028 NR=4, in_key=0, in_data=0x0000 -> out_data=0x0000, out_valid rising 4 cycles after accept.
REQ-029 NR=4, in_key=0, in_data=0xEEEE -> out_data=0xEEEE.
REQ-030 NR=4, K_4=0x1234, K_0..K_3=0, in_data=0x1234 -> out_data=0x0000.
REQ-031 1000 random key/plaintext pairs encrypted by golden model, fed with random in_valid/out_ready stalls -> every out_data equals original plaintext, no drops or duplicates.
REQ-032 Change in_key/in_data during RUN and hold out_ready=0 for 10 cycles in DONE -> result unchanged, out_valid held, in_ready=0 throughout.
REQ-033 Assert rst 2 cycles into RUN -> out_valid never rises for that request, in_ready=1 after release, next request decrypts correctly.
